// File: rtl/hs_cache_reg_initiator.sv
// hs_cache_reg_initiator: clocked four-phase (return-to-zero) req/ack initiator.
// It reads one word from the asynchronous cache responder and then writes that
// word into the register file with a one-cycle pulse.
// Optional build macro HS_STATS_EN adds the xfer_count / err_count outputs.
module hs_cache_reg_initiator #(
  parameter int unsigned N            = 32,
  parameter int unsigned address_size = 12,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [address_size-1:0] cmd_cache_ra,
  input  logic [3:0]              cmd_reg_wa,
  output logic                    req,
  input  logic                    ack,
  output logic                    cache_re,
  output logic [address_size-1:0] cache_ra,
  input  logic [N-1:0]            rd_data,
  output logic                    reg_we,
  output logic [3:0]              reg_wa,
  output logic [N-1:0]            reg_wdata,
  output logic                    done,
  output logic                    err
`ifdef HS_STATS_EN
  ,
  output logic [15:0]             xfer_count,
  output logic [7:0]              err_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    WRITE,
    ABORT,
    DRAIN
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [7:0]             to_cnt;

  // Synchronise the asynchronous ack; every decision below uses ack_s only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Handshake sequencer; all outputs are registered and change with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      req       <= 1'b0;
      cache_re  <= 1'b0;
      cache_ra  <= '0;
      reg_we    <= 1'b0;
      reg_wa    <= '0;
      reg_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      to_cnt    <= '0;
    end else begin
      reg_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cache_ra  <= cmd_cache_ra;
            reg_wa    <= cmd_reg_wa;
            req       <= 1'b1;
            cache_re  <= 1'b1;
            cmd_ready <= 1'b0;
            to_cnt    <= '0;
            state     <= REQ_HI;
          end
        end
        REQ_HI: begin
          // An ack seen on the deadline cycle still completes the capture
          if (ack_s) begin
            reg_wdata <= rd_data;
            req       <= 1'b0;
            cache_re  <= 1'b0;
            to_cnt    <= '0;
            state     <= REQ_LO;
          end else if (to_cnt == TIMEOUT_CNT) begin
            req       <= 1'b0;
            cache_re  <= 1'b0;
            err       <= 1'b1;
            to_cnt    <= '0;
            state     <= ABORT;
          end else begin
            to_cnt    <= to_cnt + 8'd1;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            reg_we    <= 1'b1;
            done      <= 1'b1;
            to_cnt    <= '0;
            state     <= WRITE;
          end else if (to_cnt == TIMEOUT_CNT) begin
            err       <= 1'b1;
            to_cnt    <= '0;
            state     <= ABORT;
          end else begin
            to_cnt    <= to_cnt + 8'd1;
          end
        end
        WRITE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        ABORT: begin
          to_cnt    <= '0;
          state     <= DRAIN;
        end
        DRAIN: begin
          if (!ack_s) begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          req       <= 1'b0;
          cache_re  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef HS_STATS_EN
  // Transfer and error counters, bumped the cycle after each done/err pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
      err_count  <= '0;
    end else begin
      if (done) begin
        xfer_count <= xfer_count + 16'd1;
      end
      if (err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hs_cache_reg_initiator.sv
// Bench for hs_cache_reg_initiator: a cycle-programmable responder plus a
// transaction-level timeline model that predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_hs_cache_reg_initiator;

  localparam int N  = 32;
  localparam int AW = 12;
  localparam int T  = 255;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_cache_ra = '0;
  logic [3:0]    cmd_reg_wa = '0;
  logic          req;
  logic          ack = 1'b0;
  logic          cache_re;
  logic [AW-1:0] cache_ra;
  logic [N-1:0]  rd_data = '0;
  logic          reg_we;
  logic [3:0]    reg_wa;
  logic [N-1:0]  reg_wdata;
  logic          done;
  logic          err;
`ifdef HS_STATS_EN
  logic [15:0]   xfer_count;
  logic [7:0]    err_count;
`endif

  hs_cache_reg_initiator #(
    .N(N), .address_size(AW), .TIMEOUT(T), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_cache_ra(cmd_cache_ra), .cmd_reg_wa(cmd_reg_wa), .req(req), .ack(ack),
    .cache_re(cache_re), .cache_ra(cache_ra), .rd_data(rd_data), .reg_we(reg_we),
    .reg_wa(reg_wa), .reg_wdata(reg_wdata), .done(done), .err(err)
`ifdef HS_STATS_EN
    , .xfer_count(xfer_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Driver-side transaction attributes (responder delays and read data)
  int          drv_d1 = 0;
  int          drv_d2 = 0;
  logic [31:0] drv_data = '0;

  // Timeline model: absolute cycle numbers of the current transaction
  bit          skip = 1'b1;
  int          ta, t_req_end, t_ready, t_w, t_abort;
  int          n_accept = 0;
  int          mdl_xfer, mdl_err;
  logic [AW-1:0] tx_ra;
  logic [3:0]  tx_wa;
  logic [31:0] tx_data;
  int          tx_d1 = -1;
  int          tx_d2 = 0;

  task automatic model_reset();
    ta = -10; t_req_end = -10; t_ready = -10; t_w = -10; t_abort = -10;
    mdl_xfer = 0; mdl_err = 0;
  endtask

  always @(negedge clk) begin : cmp
    int c, h;
    bit e_busy, e_req, e_we, e_err;
    if (!skip) begin
      c      = cyc;
      e_busy = (c >= ta) && (c < t_ready);
      e_req  = (c >= ta) && (c < t_req_end);
      e_we   = (c == t_w);
      e_err  = (c == t_abort);
      chk("cmd_ready", 64'(cmd_ready), 64'(!e_busy));
      chk("req", 64'(req), 64'(e_req));
      chk("cache_re", 64'(cache_re), 64'(e_req));
      chk("reg_we", 64'(reg_we), 64'(e_we));
      chk("done", 64'(done), 64'(e_we));
      chk("err", 64'(err), 64'(e_err));
      if (e_req) chk("cache_ra", 64'(cache_ra), 64'(tx_ra));
      if (e_we) begin
        chk("reg_wa", 64'(reg_wa), 64'(tx_wa));
        chk("reg_wdata", 64'(reg_wdata), 64'(tx_data));
      end
`ifdef HS_STATS_EN
      chk("xfer_count", 64'(xfer_count), 64'(mdl_xfer & 'hFFFF));
      chk("err_count", 64'(err_count), 64'((mdl_err > 255) ? 255 : mdl_err));
`endif
      if (e_we) mdl_xfer++;
      if (e_err) mdl_err++;
      if (!e_busy && cmd_valid) begin
        ta = c + 1;
        tx_ra = cmd_cache_ra; tx_wa = cmd_reg_wa; tx_data = drv_data;
        tx_d1 = drv_d1; tx_d2 = drv_d2;
        n_accept++;
        t_w = -10; t_abort = -10;
        if (tx_d1 < 0 || tx_d1 + S > T) begin
          t_req_end = ta + T + 1;
          t_abort   = ta + T + 1;
          t_ready   = ta + T + 3;
        end else begin
          h = ta + tx_d1 + S + 1;
          t_req_end = h;
          if (tx_d2 + S > T) begin
            t_abort = h + T + 1;
            t_ready = ((h + T + 2 > h + tx_d2 + S) ? h + T + 2 : h + tx_d2 + S) + 1;
          end else begin
            t_w     = h + tx_d2 + S + 1;
            t_ready = t_w + 1;
          end
        end
      end
    end
  end

  // Responder: raises ack tx_d1 cycles after seeing req, drops it tx_d2 cycles after req falls
  initial begin : responder
    int hi_cnt, lo_cnt;
    hi_cnt = 0; lo_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack = 1'b0; hi_cnt = 0; lo_cnt = 0;
      end else if (!ack) begin
        if (req && tx_d1 >= 0) begin
          if (hi_cnt >= tx_d1) begin ack = 1'b1; rd_data = tx_data; lo_cnt = 0; end
          else hi_cnt++;
        end else hi_cnt = 0;
      end else begin
        if (!req) begin
          if (lo_cnt >= tx_d2) begin ack = 1'b0; hi_cnt = 0; rd_data = $urandom; end
          else lo_cnt++;
        end else lo_cnt = 0;
      end
    end
  end

  // DUT event observation for the hand-computed timing checks
  int          req_rise_cyc = 0, ready_rise_cyc = 0, err_cyc = 0, we_cyc = 0;
  int          dut_we_count = 0, dut_done_count = 0;
  logic [AW-1:0] ra_at_rise = '0;
  logic [3:0]  we_wa = '0;
  logic [31:0] we_data = '0;
  logic [3:0]  we_q[$];
  bit          prev_req = 1'b0, prev_ready = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req && !prev_req) begin req_rise_cyc = cyc; ra_at_rise = cache_ra; end
      if (cmd_ready && !prev_ready) ready_rise_cyc = cyc;
      if (reg_we) begin
        dut_we_count++; we_cyc = cyc; we_wa = reg_wa; we_data = reg_wdata;
        we_q.push_back(reg_wa);
      end
      if (done) dut_done_count++;
      if (err) err_cyc = cyc;
    end
    prev_req = req; prev_ready = cmd_ready;
  end

  task automatic run_cmd(input logic [AW-1:0] ra, input logic [3:0] wa, input int d1,
                         input int d2, input logic [31:0] data, input bit hold);
    int start, budget;
    start = n_accept;
    cmd_cache_ra = ra; cmd_reg_wa = wa; drv_d1 = d1; drv_d2 = d2; drv_data = data;
    cmd_valid = 1'b1;
    budget = 0;
    while (n_accept == start && budget < 3000) begin @(posedge clk); #1; budget++; end
    if (n_accept == start) begin
      n_checks++; n_err++;
      $display("FAIL accept_wait: no accept within %0d cycles", budget);
    end
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (cyc < t_ready + 1 && budget < 3000) begin @(posedge clk); #1; budget++; end
    if (budget >= 3000) begin
      n_checks++; n_err++;
      $display("FAIL idle_wait: still busy after %0d cycles", budget);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "time limit");
  end

  initial begin : main
    int w0, d0, e0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_cache_re", 64'(cache_re), 64'd0);
    chk("rst_reg_we", 64'(reg_we), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cache_ra", 64'(cache_ra), 64'd0);
    chk("rst_reg_wa", 64'(reg_wa), 64'd0);
    chk("rst_reg_wdata", 64'(reg_wdata), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_reset();
    skip = 1'b0;
    @(posedge clk); #1;

    // Ideal responder: accept-to-write latency 7
    w0 = dut_we_count; d0 = dut_done_count;
    run_cmd(12'h0A5, 4'd3, 0, 0, 32'hDEADBEEF, 1'b0);
    wait_idle();
    chk("ideal_latency", 64'(we_cyc - (req_rise_cyc - 1)), 64'd7);
    chk("ideal_reg_wa", 64'(we_wa), 64'd3);
    chk("ideal_reg_wdata", 64'(we_data), 64'hDEADBEEF);
    chk("ideal_cache_ra", 64'(ra_at_rise), 64'h0A5);
    chk("ideal_we_pulses", 64'(dut_we_count - w0), 64'd1);
    chk("ideal_done_pulses", 64'(dut_done_count - d0), 64'd1);

    // ack held 1000 cycles after req falls: abort in REQ_LO, DRAIN until ack low
    w0 = dut_we_count;
    run_cmd(12'h123, 4'd5, 0, 1000, 32'h0BADF00D, 1'b0);
    wait_idle();
    chk("lo_to_ready_gap", 64'(ready_rise_cyc - err_cyc), 64'd747);
    chk("lo_to_no_write", 64'(dut_we_count - w0), 64'd0);
`ifdef HS_STATS_EN
    chk("lo_to_err_count", 64'(err_count), 64'd1);
`endif

    // Responder never acks: err exactly TIMEOUT+1 cycles after req rises
    w0 = dut_we_count; e0 = mdl_err;
    run_cmd(12'h7FF, 4'd9, -1, 0, 32'h12345678, 1'b0);
    wait_idle();
    chk("hi_to_err_delay", 64'(err_cyc - req_rise_cyc), 64'd256);
    chk("hi_to_no_write", 64'(dut_we_count - w0), 64'd0);

    // Boundary: ack falls one cycle too late to beat the REQ_LO deadline
    run_cmd(12'h001, 4'd1, 1, T - S + 1, 32'hCAFE0001, 1'b0);
    wait_idle();
    // Boundary: ack rises on the last cycle before the REQ_HI deadline
    run_cmd(12'h002, 4'd2, T - S - 1, 2, 32'hCAFE0002, 1'b0);
    wait_idle();

    // Reset while req is high in REQ_HI: outputs clear without a clock edge
    run_cmd(12'h3C3, 4'd7, 100, 0, 32'h55AA55AA, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    skip = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(req), 64'd0);
    chk("arst_cache_re", 64'(cache_re), 64'd0);
    chk("arst_reg_we", 64'(reg_we), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    model_reset();
    skip = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Three back-to-back commands with cmd_valid held high
    w0 = dut_we_count;
    run_cmd(12'h010, 4'd1, 0, 0, 32'h11111111, 1'b1);
    run_cmd(12'h020, 4'd2, 1, 0, 32'h22222222, 1'b1);
    run_cmd(12'h030, 4'd3, 0, 2, 32'h33333333, 1'b0);
    wait_idle();
    chk("b2b_we_pulses", 64'(dut_we_count - w0), 64'd3);
    if (we_q.size() >= 3) begin
      chk("b2b_order0", 64'(we_q[we_q.size()-3]), 64'd1);
      chk("b2b_order1", 64'(we_q[we_q.size()-2]), 64'd2);
      chk("b2b_order2", 64'(we_q[we_q.size()-1]), 64'd3);
    end else begin
      chk("b2b_queue_depth", 64'(we_q.size()), 64'd3);
    end
`ifdef HS_STATS_EN
    chk("b2b_xfer_count", 64'(xfer_count), 64'd3);
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin : rnd
      int gap, d1, d2;
      bit hold;
      gap = $urandom_range(0, 3);
      if (!cmd_valid) repeat (gap) begin @(posedge clk); #1; end
      d1 = ($urandom_range(0, 15) == 0) ? T - S - 1 : $urandom_range(0, 6);
      d2 = $urandom_range(0, 6);
      hold = (i != 39) && ($urandom_range(0, 1) == 1);
      run_cmd(AW'($urandom), 4'($urandom), d1, d2, $urandom, hold);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
